// File: rtl/flash_pkg.sv
// rtl/flash_pkg.sv - shared widths, register offsets and FSM encoding for flash_cntrl_ws
package flash_pkg;

  localparam int ADDR_W_DEF = 21;
  localparam int DATA_W_DEF = 16;
  localparam int WB_AW_DEF  = 17;
  localparam int WIN_W_DEF  = 8;
  localparam int WS_W_DEF   = 4;
  localparam int WS_RST_DEF = 3;

  localparam logic REG_BASE = 1'b0;
  localparam logic REG_WS   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_REGACK = 3'd2,
    ST_ACK    = 3'd3
`ifdef FLASH_PROG_EN
    , ST_PROG = 3'd4
`endif
  } state_t;

endpackage

// File: rtl/flash_cntrl_ws_if.sv
// rtl/flash_cntrl_ws_if.sv - Wishbone slave bus bundle for flash_cntrl_ws
interface flash_cntrl_ws_if
  import flash_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int WB_AW  = WB_AW_DEF
);
  logic [DATA_W-1:0] wb_dat_i;
  logic [DATA_W-1:0] wb_dat_o;
  logic [WB_AW:1]    wb_adr_i;
  logic              wb_we_i;
  logic              wb_tga_i;
  logic              wb_sel_i;
  logic              wb_stb_i;
  logic              wb_cyc_i;
  logic              wb_ack_o;

  modport master (
    output wb_dat_i, wb_adr_i, wb_we_i, wb_tga_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_dat_i, wb_adr_i, wb_we_i, wb_tga_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/flash_wait_cnt.sv
// rtl/flash_wait_cnt.sv - loadable wait-state down-counter with zero flag
module flash_wait_cnt #(
  parameter int WS_W = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            load_i,
  input  logic [WS_W-1:0] load_val_i,
  input  logic            dec_i,
  output logic [WS_W-1:0] cnt_o,
  output logic            zero_o
);
  logic [WS_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - WS_W'(1);
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/flash_cntrl_ws.sv
// rtl/flash_cntrl_ws.sv - Wishbone flash controller with wait-state FSM and window base
// Optional program (write-strobe) path enabled by FLASH_PROG_EN.
module flash_cntrl_ws
  import flash_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int WB_AW  = WB_AW_DEF,
  parameter int WIN_W  = WIN_W_DEF,
  parameter int WS_W   = WS_W_DEF,
  parameter int WS_RST = WS_RST_DEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  flash_cntrl_ws_if.slave   wb,
  output logic [ADDR_W-1:0] flash_addr_,
  input  logic [DATA_W-1:0] flash_data_i,
  output logic [DATA_W-1:0] flash_data_o,
  output logic              flash_data_oe,
  output logic              flash_ce2_,
  output logic              flash_oe_n_,
  output logic              flash_we_n_
);
  localparam int BASE_W = ADDR_W - 1 - WIN_W;

  state_t              state_q, state_d;
  logic                ack_q, ack_d;
  logic [DATA_W-1:0]   dat_o_q, dat_o_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                ce2_q, ce2_d;
  logic                oe_n_q, oe_n_d;
  logic [BASE_W-1:0]   base_q, base_d;
  logic [WS_W-1:0]     ws_q, ws_d;
  logic                wr_q, wr_d;
  logic                cnt_load, cnt_dec, cnt_zero;
  logic [WS_W-1:0]     cnt_val;
  logic                op;
  logic                unused_dat;

  assign op         = wb.wb_cyc_i & wb.wb_stb_i;
  assign unused_dat = ^{wb.wb_dat_i, cnt_val};

  flash_wait_cnt #(.WS_W(WS_W)) u_wait_cnt (
    .clk_i      (wb_clk_i),
    .rst_n_i    (wb_rst_n_i),
    .load_i     (cnt_load),
    .load_val_i (ws_q),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt_val),
    .zero_o     (cnt_zero)
  );

`ifdef FLASH_PROG_EN
  logic              we_n_q, we_n_d;
  logic              doe_q, doe_d;
  logic [DATA_W-1:0] fdo_q, fdo_d;
`endif

  always_comb begin
    state_d  = state_q;
    ack_d    = 1'b0;
    dat_o_d  = dat_o_q;
    addr_d   = addr_q;
    ce2_d    = ce2_q;
    oe_n_d   = oe_n_q;
    base_d   = base_q;
    ws_d     = ws_q;
    wr_d     = wr_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
`ifdef FLASH_PROG_EN
    we_n_d   = we_n_q;
    doe_d    = doe_q;
    fdo_d    = fdo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (op && wb.wb_tga_i && wb.wb_sel_i) begin
          state_d = ST_REGACK;
          ack_d   = 1'b1;
          if (wb.wb_we_i) begin
            if (wb.wb_adr_i[1] == REG_WS) ws_d = wb.wb_dat_i[WS_W-1:0];
            else                          base_d = wb.wb_dat_i[BASE_W-1:0];
          end else begin
            dat_o_d = (wb.wb_adr_i[1] == REG_WS) ? DATA_W'(ws_q) : DATA_W'(base_q);
          end
        end else if (op) begin
          cnt_load = 1'b1;
          wr_d     = wb.wb_we_i;
          addr_d   = wb.wb_tga_i ? {1'b1, base_q, wb.wb_adr_i[WIN_W:1]}
                                 : ADDR_W'(wb.wb_adr_i);
`ifdef FLASH_PROG_EN
          if (wb.wb_we_i) begin
            state_d = ST_PROG;
            ce2_d   = 1'b1;
            we_n_d  = 1'b0;
            doe_d   = 1'b1;
            fdo_d   = wb.wb_dat_i;
          end else begin
            state_d = ST_ACCESS;
            ce2_d   = 1'b1;
            oe_n_d  = 1'b0;
          end
`else
          // Writes without the program path only borrow the read timing.
          state_d = ST_ACCESS;
          if (!wb.wb_we_i) begin
            ce2_d  = 1'b1;
            oe_n_d = 1'b0;
          end
`endif
        end
      end
      ST_REGACK: state_d = ST_IDLE;
      ST_ACCESS: begin
        if (!wb.wb_cyc_i) begin
          state_d = ST_IDLE;
          ce2_d   = 1'b0;
          oe_n_d  = 1'b1;
        end else if (cnt_zero) begin
          if (!wr_q) dat_o_d = flash_data_i;
          state_d = ST_ACK;
          ack_d   = 1'b1;
          ce2_d   = 1'b0;
          oe_n_d  = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
`ifdef FLASH_PROG_EN
      ST_PROG: begin
        if (!wb.wb_cyc_i || cnt_zero) begin
          state_d = wb.wb_cyc_i ? ST_ACK : ST_IDLE;
          ack_d   = wb.wb_cyc_i;
          ce2_d   = 1'b0;
          we_n_d  = 1'b1;
          doe_d   = 1'b0;
        end else begin
          cnt_dec = 1'b1;
        end
      end
`endif
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      dat_o_q <= '0;
      addr_q  <= '0;
      ce2_q   <= 1'b0;
      oe_n_q  <= 1'b1;
      base_q  <= '0;
      ws_q    <= WS_W'(WS_RST);
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dat_o_q <= dat_o_d;
      addr_q  <= addr_d;
      ce2_q   <= ce2_d;
      oe_n_q  <= oe_n_d;
      base_q  <= base_d;
      ws_q    <= ws_d;
      wr_q    <= wr_d;
    end
  end

`ifdef FLASH_PROG_EN
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      we_n_q <= 1'b1;
      doe_q  <= 1'b0;
      fdo_q  <= '0;
    end else begin
      we_n_q <= we_n_d;
      doe_q  <= doe_d;
      fdo_q  <= fdo_d;
    end
  end

  assign flash_we_n_   = we_n_q;
  assign flash_data_oe = doe_q;
  assign flash_data_o  = fdo_q;
`else
  assign flash_we_n_   = 1'b1;
  assign flash_data_oe = 1'b0;
  assign flash_data_o  = '0;
`endif

  assign wb.wb_ack_o  = ack_q;
  assign wb.wb_dat_o  = dat_o_q;
  assign flash_addr_  = addr_q;
  assign flash_ce2_   = ce2_q;
  assign flash_oe_n_  = oe_n_q;
endmodule

// File: tb/tb_flash_cntrl_ws.sv
// tb/tb_flash_cntrl_ws.sv - directed table-driven bench for flash_cntrl_ws
module tb_flash_cntrl_ws;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [20:0] flash_addr;
  logic [15:0] fdi, fdo;
  logic        doe, ce2, oe_n, we_n;
  int          checks = 0;
  int          failures = 0;

`ifdef FLASH_PROG_EN
  localparam int PROG_WE = 3;
`else
  localparam int PROG_WE = 0;
`endif

  always #5 clk = ~clk;

  flash_cntrl_ws_if #(.DATA_W(16), .WB_AW(17)) wb ();

  flash_cntrl_ws dut (
    .wb_clk_i      (clk),
    .wb_rst_n_i    (rst_n),
    .wb            (wb),
    .flash_addr_   (flash_addr),
    .flash_data_i  (fdi),
    .flash_data_o  (fdo),
    .flash_data_oe (doe),
    .flash_ce2_    (ce2),
    .flash_oe_n_   (oe_n),
    .flash_we_n_   (we_n)
  );

  typedef struct {
    logic        tga, sel, we;
    logic [16:0] adr;
    logic [15:0] dat, fdata;
    int          exp_ack;
    logic        chk_rd;
    logic [15:0] exp_rd;
    logic        chk_addr;
    logic [20:0] exp_addr;
    int          exp_oe;
    int          exp_we;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic tga, sel, we, input logic [16:0] adr,
                              input logic [15:0] dat, fdata, input int exp_ack,
                              input logic chk_rd, input logic [15:0] exp_rd,
                              input logic chk_addr, input logic [20:0] exp_addr,
                              input int exp_oe, exp_we);
    vec_t v;
    v.tga = tga; v.sel = sel; v.we = we; v.adr = adr; v.dat = dat; v.fdata = fdata;
    v.exp_ack = exp_ack; v.chk_rd = chk_rd; v.exp_rd = exp_rd;
    v.chk_addr = chk_addr; v.exp_addr = exp_addr; v.exp_oe = exp_oe; v.exp_we = exp_we;
    return v;
  endfunction

  function automatic vec_t reg_op(input logic we, input logic [16:0] adr, input logic [15:0] dat,
                                  input logic chk_rd, input logic [15:0] exp_rd);
    return mk(1'b1, 1'b1, we, adr, dat, 16'h0, 1, chk_rd, exp_rd, 1'b0, 21'h0, 0, 0);
  endfunction

  // Presents one transaction at a negedge (T0) and observes it cycle by cycle.
  task automatic run_access(input vec_t v, output int ack_at, output logic [15:0] rd,
                            output logic [20:0] a1, output int oe_low, output int we_low,
                            output int doe_cnt, output int fdo_bad);
    wb.wb_tga_i = v.tga; wb.wb_sel_i = v.sel; wb.wb_we_i = v.we;
    wb.wb_adr_i = v.adr; wb.wb_dat_i = v.dat; fdi = v.fdata;
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
    ack_at = -1; rd = '0; a1 = '0; oe_low = 0; we_low = 0; doe_cnt = 0; fdo_bad = 0;
    for (int k = 1; k <= 40 && ack_at < 0; k++) begin
      @(negedge clk);
      if (k == 1) a1 = flash_addr;
      if (!oe_n) oe_low++;
      if (!we_n) begin
        we_low++;
        if (fdo !== v.dat) fdo_bad++;
      end
      if (doe) doe_cnt++;
      if (wb.wb_ack_o) begin
        ack_at = k;
        rd = wb.wb_dat_o;
      end
    end
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int          ack_at, oe_low, we_low, doe_cnt, fdo_bad, ack_seen;
    logic [15:0] rd;
    logic [20:0] a1;

    // ws starts at 3, base at 0; expectations follow the running register state.
    vecs[0]  = reg_op(1'b0, 17'h1, 16'h0, 1'b1, 16'h0003);
    vecs[1]  = reg_op(1'b0, 17'h0, 16'h0, 1'b1, 16'h0000);
    vecs[2]  = reg_op(1'b1, 17'h1, 16'h0000, 1'b0, 16'h0);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 17'h12345, 16'h0, 16'hBEEF, 2, 1'b1, 16'hBEEF, 1'b1, 21'h012345, 1, 0);
    vecs[4]  = reg_op(1'b1, 17'h0, 16'h0A5C, 1'b0, 16'h0);
    vecs[5]  = reg_op(1'b1, 17'h1, 16'h0005, 1'b0, 16'h0);
    vecs[6]  = reg_op(1'b0, 17'h1, 16'h0, 1'b1, 16'h0005);
    vecs[7]  = reg_op(1'b0, 17'h0, 16'h0, 1'b1, 16'h0A5C);
    vecs[8]  = mk(1'b1, 1'b0, 1'b0, 17'h0007F, 16'h0, 16'h1357, 7, 1'b1, 16'h1357, 1'b1, 21'h1A5C7F, 6, 0);
    vecs[9]  = mk(1'b1, 1'b0, 1'b0, 17'h001FF, 16'h0, 16'h2468, 7, 1'b1, 16'h2468, 1'b1, 21'h1A5CFF, 6, 0);
    vecs[10] = reg_op(1'b1, 17'h1, 16'h000F, 1'b0, 16'h0);
    vecs[11] = mk(1'b0, 1'b0, 1'b0, 17'h1FFFF, 16'h0, 16'hFFFF, 17, 1'b1, 16'hFFFF, 1'b1, 21'h01FFFF, 16, 0);
    vecs[12] = reg_op(1'b1, 17'h1, 16'hFFF2, 1'b0, 16'h0);
    vecs[13] = reg_op(1'b0, 17'h1, 16'h0, 1'b1, 16'h0002);
    vecs[14] = mk(1'b0, 1'b0, 1'b1, 17'h00010, 16'h1234, 16'hCCCC, 4, 1'b0, 16'h0, 1'b1, 21'h000010, 0, PROG_WE);
    vecs[15] = mk(1'b0, 1'b0, 1'b0, 17'h00000, 16'h0, 16'h0001, 4, 1'b1, 16'h0001, 1'b1, 21'h000000, 3, 0);
    vecs[16] = reg_op(1'b1, 17'h1, 16'h000A, 1'b0, 16'h0);

    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0; wb.wb_tga_i = 1'b0;
    wb.wb_sel_i = 1'b0; wb.wb_adr_i = '0; wb.wb_dat_i = '0; fdi = '0;

    repeat (3) @(negedge clk);
    chk("rst_ack", wb.wb_ack_o, 0);
    chk("rst_dat", wb.wb_dat_o, 0);
    chk("rst_addr", flash_addr, 0);
    chk("rst_ce2", ce2, 0);
    chk("rst_oe_n", oe_n, 1);
    chk("rst_we_n", we_n, 1);
    chk("rst_doe", doe, 0);
    chk("rst_fdo", fdo, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      run_access(vecs[i], ack_at, rd, a1, oe_low, we_low, doe_cnt, fdo_bad);
      chk($sformatf("v%0d_ack_cycle", i), ack_at, vecs[i].exp_ack);
      chk($sformatf("v%0d_ack_pulse", i), wb.wb_ack_o, 0);
      chk($sformatf("v%0d_oe_low", i), oe_low, vecs[i].exp_oe);
      chk($sformatf("v%0d_we_low", i), we_low, vecs[i].exp_we);
      chk($sformatf("v%0d_doe", i), doe_cnt, vecs[i].exp_we);
      chk($sformatf("v%0d_fdo", i), fdo_bad, 0);
      if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      if (vecs[i].chk_addr) chk($sformatf("v%0d_addr", i), a1, vecs[i].exp_addr);
    end

    // Abort: ws=10, cyc dropped at T4.
    wb.wb_tga_i = 1'b0; wb.wb_sel_i = 1'b0; wb.wb_we_i = 1'b0;
    wb.wb_adr_i = 17'h00ABC; fdi = 16'h7777;
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
    repeat (4) @(negedge clk);
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
    @(negedge clk);
    chk("abort_ce2", ce2, 0);
    chk("abort_oe_n", oe_n, 1);
    ack_seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (wb.wb_ack_o) ack_seen = 1;
      @(negedge clk);
    end
    chk("abort_no_ack", ack_seen, 0);
    chk("abort_dat", wb.wb_dat_o, 16'h0001);
    run_access(mk(1'b0, 1'b0, 1'b0, 17'h00ABC, 16'h0, 16'h5A5A, 12, 1'b1, 16'h5A5A, 1'b1, 21'h000ABC, 11, 0),
               ack_at, rd, a1, oe_low, we_low, doe_cnt, fdo_bad);
    chk("post_abort_ack", ack_at, 12);
    chk("post_abort_rd", rd, 16'h5A5A);

    // Asynchronous reset in the middle of an access.
    run_access(reg_op(1'b1, 17'h0, 16'h0123, 1'b0, 16'h0), ack_at, rd, a1, oe_low, we_low, doe_cnt, fdo_bad);
    run_access(reg_op(1'b1, 17'h1, 16'h0007, 1'b0, 16'h0), ack_at, rd, a1, oe_low, we_low, doe_cnt, fdo_bad);
    wb.wb_tga_i = 1'b1; wb.wb_sel_i = 1'b0; wb.wb_we_i = 1'b0;
    wb.wb_adr_i = 17'h00011; fdi = 16'h9999;
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_ce2", ce2, 1);
    chk("pre_rst_addr", flash_addr, 21'h112311);
    rst_n = 1'b0;
    #1;
    chk("arst_ack", wb.wb_ack_o, 0);
    chk("arst_dat", wb.wb_dat_o, 0);
    chk("arst_addr", flash_addr, 0);
    chk("arst_ce2", ce2, 0);
    chk("arst_oe_n", oe_n, 1);
    chk("arst_we_n", we_n, 1);
    @(negedge clk);
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    run_access(reg_op(1'b0, 17'h0, 16'h0, 1'b1, 16'h0), ack_at, rd, a1, oe_low, we_low, doe_cnt, fdo_bad);
    chk("arst_base_ack", ack_at, 1);
    chk("arst_base", rd, 16'h0000);
    run_access(reg_op(1'b0, 17'h1, 16'h0, 1'b1, 16'h0), ack_at, rd, a1, oe_low, we_low, doe_cnt, fdo_bad);
    chk("arst_ws", rd, 16'h0003);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/flash_cntrl_ws.md
Name: flash_cntrl_ws

Overview:
Parametrised Wishbone-slave flash controller; successor to the fixed-timing flash read path. Adds a programmable wait-state FSM, a configurable window base register and a register readback path, with generic address/data widths. Sits between the memory-map decoder and the flash pads. A compile-time option adds a program (write-strobe) path.

Parameters:
ADDR_W, 21, flash word-address width (flash_addr_ width)
DATA_W, 16, flash and Wishbone data width
WB_AW, 17, Wishbone word-address width; wb_adr_i is [WB_AW:1]
WIN_W, 8, window offset bits; base width BASE_W = ADDR_W-1-WIN_W
WS_W, 4, wait-state register width
WS_RST, 3, wait-state count after reset

Ports:
wb_clk_i  in  1  clock
wb_rst_n_i  in  1  asynchronous reset, active low
wb_dat_i  in  DATA_W  write data
wb_dat_o  out  DATA_W  registered read data
wb_adr_i  in  WB_AW  word address [WB_AW:1]
wb_we_i  in  1  write enable
wb_tga_i  in  1  1 = window/register space, 0 = direct flash space
wb_sel_i  in  1  with tga=1: 0 = flash window, 1 = control registers
wb_stb_i  in  1  strobe
wb_cyc_i  in  1  cycle
wb_ack_o  out  1  one-cycle acknowledge
flash_addr_  out  ADDR_W  flash address
flash_data_i  in  DATA_W  flash read data
flash_data_o  out  DATA_W  flash write data
flash_data_oe  out  1  pad output enable for flash_data_o
flash_ce2_  out  1  chip enable, active high
flash_oe_n_  out  1  output enable, active low
flash_we_n_  out  1  write enable, active low

Behaviour:
- Reset (async, wb_rst_n_i low): state IDLE; wb_ack_o=0, wb_dat_o=0, flash_addr_=0, flash_ce2_=0, flash_oe_n_=1, flash_we_n_=1, flash_data_oe=0, flash_data_o=0, base=0, ws=WS_RST. Assertion mid-access aborts immediately with no ack.
- op = wb_cyc_i & wb_stb_i, sampled only in IDLE.
- Address mapping, latched on IDLE->ACCESS: tga=0: flash_addr_ = zero-extended wb_adr_i[WB_AW:1]. tga=1, sel=0: {1'b1, base, wb_adr_i[WIN_W:1]}.
- Registers (tga=1, sel=1), selected by wb_adr_i[1]: 0 = base[BASE_W-1:0], 1 = ws[WS_W-1:0]. Writes load from low bits of wb_dat_i; reads return zero-extended value. No flash strobes asserted.
- FSM states: IDLE, ACCESS, REGACK, ACK, plus PROG when FLASH_PROG_EN is defined.
  IDLE: op & register access -> REGACK (register written/read on this edge). op & flash read -> ACCESS; cnt<=ws; ce2=1; oe_n=0.
  REGACK: ack=1 for one cycle -> IDLE. Register access latency: ack in cycle T1 after stb seen at T0.
  ACCESS: if cnt!=0, cnt--. If cnt==0, wb_dat_o<=flash_data_i and go to ACK.
  ACK: ack=1 one cycle; ce2=0, oe_n=1 -> IDLE.
- Read latency: stb seen at T0, ack high in cycle T(ws+2). ws=0 gives ack at T2; ws=15 gives ack at T17.
- Abort: wb_cyc_i low in ACCESS or PROG -> IDLE next cycle, strobes deasserted, no ack, registers unchanged.
- A ws write takes effect from the next access. An access already in flight keeps its loaded cnt.
- Back-to-back: a new op is only sampled in IDLE, so there is a minimum of one idle cycle between acks.
- Flash write, tga=1 sel=0 or tga=0, with the feature disabled: acked through ACCESS timing with no strobe; flash_we_n_ stays 1 and data is discarded.

Optional Feature:
FLASH_PROG_EN. When defined, a flash-space write goes IDLE->PROG with cnt<=ws. In PROG: ce2=1, we_n=0, oe_n=1, flash_data_oe=1, flash_data_o=wb_dat_i (latched). PROG exits to ACK when cnt==0; we_n returns to 1 and data_oe to 0 in ACK. The write pulse width is ws+1 cycles. When undefined, the PROG state, flash_data_o and data_oe logic are absent: flash_data_o=0, flash_data_oe=0, flash_we_n_=1 constant.

Decomposition:
- Package flash_pkg: state encoding localparams, register offsets (REG_BASE=0, REG_WS=1), default widths.
- One natural sub-module: flash_wait_cnt (loadable down-counter with zero flag, WS_W wide), shared by ACCESS and PROG.

Test Plan:
- Reset: ws readback after reset; read register 1 -> wb_dat_o=3 with ack at T1.
- Direct read: ws=0, tga=0, adr=0x1_2345, flash_data_i=0xBEEF -> flash_addr_=0x012345, oe_n=0 at T1, ack at T2, wb_dat_o=0xBEEF.
- Window read: write base=0xA5C, ws=5, then read tga=1 sel=0 adr[8:1]=0x7F -> flash_addr_={1,0xA5C,0x7F}, ack exactly at T7.
- Abort: ws=10, drop wb_cyc_i at T4 -> no ack, ce2=0 and oe_n=1 at T5, next read completes normally.
- Async reset mid-ACCESS: assert wb_rst_n_i low at T3 -> all outputs reach reset values without a clock edge; base returns to 0.
- FLASH_PROG_EN: ws=2, write 0x1234 to tga=0 adr=0x10 -> we_n low for 3 cycles with data_oe=1 and flash_data_o=0x1234, then ack. Without the macro: ack arrives and we_n stays 1.
